// File: rtl/vec_buf_pkg.sv
// vec_buf_pkg: shared bank select type and chunk geometry helpers for vec_chunk_buffer
package vec_buf_pkg;
  typedef logic bank_sel_t;
  function automatic int chunk_count(input int vec_length, input int working_regs);
    return vec_length / working_regs;
  endfunction
  function automatic int ptr_width(input int vec_length, input int working_regs);
    return (vec_length / working_regs > 1) ? $clog2(vec_length / working_regs) : 1;
  endfunction
endpackage

// File: rtl/vec_bank.sv
// vec_bank: one vector storage bank, element-wise write, combinational chunk read
module vec_bank
  import vec_buf_pkg::*;
#(
  parameter int VecLength   = 16,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8,
  localparam int IdxW = (VecLength > 1) ? $clog2(VecLength) : 1,
  localparam int PtrW = ptr_width(VecLength, WorkingRegs)
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   wr_en,
  input  logic [IdxW-1:0]                        wr_idx,
  input  logic signed [NBits-1:0]                wr_data,
  input  logic [PtrW-1:0]                        rd_ptr,
  output logic signed [WorkingRegs-1:0][NBits-1:0] rd_chunk
);
  logic [VecLength-1:0][NBits-1:0] mem;
  logic [IdxW-1:0] base;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) mem <= '0;
    else if (wr_en) mem[wr_idx] <= wr_data;
  assign base = IdxW'(rd_ptr) * IdxW'(WorkingRegs);
  assign rd_chunk = mem[base +: WorkingRegs];
endmodule

// File: rtl/vec_chunk_buffer.sv
// vec_chunk_buffer: ping-pong vector buffer serving stored vectors one chunk at a time
// Optional sticky overflow flag and assertion enabled by VEC_CHUNK_BUFFER_OVERFLOW_FLAG_EN.
module vec_chunk_buffer
  import vec_buf_pkg::*;
#(
  parameter int VecLength   = 16,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     wr_valid,
  input  logic signed [NBits-1:0]                  wr_data,
  input  logic                                     req_chunk_in,
  input  logic                                     req_chunk_ptr_rst,
  input  logic                                     rd_release,
  output logic signed [WorkingRegs-1:0][NBits-1:0] out_data,
  output logic                                     out_data_ready,
  output logic                                     wr_overflow
);
  localparam int NChunks = chunk_count(VecLength, WorkingRegs);
  localparam int PtrW    = ptr_width(VecLength, WorkingRegs);
  localparam int IdxW    = (VecLength > 1) ? $clog2(VecLength) : 1;
  if (VecLength % WorkingRegs != 0) begin : g_bad_geom
    $error("VecLength must be a multiple of WorkingRegs");
  end
  bank_sel_t       wr_bank, rd_bank, wr_bank_nx, rd_bank_nx;
  logic [IdxW-1:0] wr_idx, wr_idx_nx;
  logic [PtrW-1:0] rd_ptr, rd_ptr_nx;
  logic [1:0]      full_cnt, full_cnt_nx;
  logic            wr_ok, wr_last, rel;
  logic signed [WorkingRegs-1:0][NBits-1:0] chunk0, chunk1;
  assign wr_ok   = wr_valid && full_cnt != 2'd2;
  assign wr_last = wr_ok && wr_idx == IdxW'(VecLength - 1);
  assign rel     = rd_release && full_cnt != 2'd0;
  always_comb begin
    wr_idx_nx   = wr_last ? '0 : wr_ok ? wr_idx + IdxW'(1) : wr_idx;
    wr_bank_nx  = wr_last ? ~wr_bank : wr_bank;
    rd_bank_nx  = rel ? ~rd_bank : rd_bank;
    rd_ptr_nx   = (rel || req_chunk_ptr_rst) ? '0 :
                  !req_chunk_in ? rd_ptr :
                  rd_ptr == PtrW'(NChunks - 1) ? '0 : rd_ptr + PtrW'(1);
    full_cnt_nx = full_cnt + {1'b0, wr_last} - {1'b0, rel};
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      wr_bank  <= '0;
      wr_idx   <= '0;
      rd_bank  <= '0;
      rd_ptr   <= '0;
      full_cnt <= '0;
    end else begin
      wr_bank  <= wr_bank_nx;
      wr_idx   <= wr_idx_nx;
      rd_bank  <= rd_bank_nx;
      rd_ptr   <= rd_ptr_nx;
      full_cnt <= full_cnt_nx;
    end
  vec_bank #(.VecLength(VecLength), .WorkingRegs(WorkingRegs), .NBits(NBits)) u_bank0 (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_ok && wr_bank == 1'b0),
    .wr_idx(wr_idx), .wr_data(wr_data), .rd_ptr(rd_ptr), .rd_chunk(chunk0)
  );
  vec_bank #(.VecLength(VecLength), .WorkingRegs(WorkingRegs), .NBits(NBits)) u_bank1 (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_ok && wr_bank == 1'b1),
    .wr_idx(wr_idx), .wr_data(wr_data), .rd_ptr(rd_ptr), .rd_chunk(chunk1)
  );
  assign out_data       = rd_bank ? chunk1 : chunk0;
  assign out_data_ready = full_cnt != 2'd0;
`ifdef VEC_CHUNK_BUFFER_OVERFLOW_FLAG_EN
  logic ovf;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) ovf <= 1'b0;
    else if (wr_valid && full_cnt == 2'd2) ovf <= 1'b1;
  assign wr_overflow = ovf;
`ifndef SYNTHESIS
  ovf_a: assert property (@(posedge clk_in) disable iff (rst_in) !(wr_valid && full_cnt == 2'd2))
    else $warning("vec_chunk_buffer: write dropped, both banks full");
`endif
`else
  assign wr_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_vec_chunk_buffer.sv
// tb_vec_chunk_buffer: queue-model and directed-vector bench for vec_chunk_buffer
module tb_vec_chunk_buffer;
  localparam int VL = 8;
  localparam int WR = 4;
  localparam int NB = 8;
  localparam int NCH = VL / WR;
`ifdef VEC_CHUNK_BUFFER_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic clk_in = 0, rst_in = 1;
  logic wr_valid = 0, req_chunk_in = 0, req_chunk_ptr_rst = 0, rd_release = 0;
  logic signed [NB-1:0] wr_data = '0;
  logic signed [WR-1:0][NB-1:0] out_data;
  logic out_data_ready, wr_overflow;
  int checks = 0, errors = 0;

  vec_chunk_buffer #(.VecLength(VL), .WorkingRegs(WR), .NBits(NB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_valid(wr_valid), .wr_data(wr_data),
    .req_chunk_in(req_chunk_in), .req_chunk_ptr_rst(req_chunk_ptr_rst),
    .rd_release(rd_release), .out_data(out_data), .out_data_ready(out_data_ready),
    .wr_overflow(wr_overflow)
  );

  initial forever #5 clk_in = ~clk_in;

  // Model: completed vectors live back to back in done[], oldest first.
  int done[$];
  int part[$];
  int ptr;
  bit ov;
  int nvec;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      done.delete(); part.delete(); ptr = 0; ov = 0;
    end else begin
      nvec = done.size() / VL;
      if (rd_release && nvec > 0) begin
        repeat (VL) void'(done.pop_front());
        ptr = 0;
      end else if (req_chunk_ptr_rst) ptr = 0;
      else if (req_chunk_in) ptr = (ptr + 1) % NCH;
      if (wr_valid) begin
        if (nvec < 2) begin
          part.push_back(int'(wr_data));
          if (part.size() == VL) begin
            foreach (part[i]) done.push_back(part[i]);
            part.delete();
          end
        end else if (OVF_EN) ov = 1;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", nm, got, got, exp, exp, $time);
    end
  endtask

  always @(negedge clk_in) if (!rst_in) begin
    chk("ready", int'(out_data_ready), int'(done.size() != 0));
    chk("overflow", int'(wr_overflow), int'(ov));
    if (done.size() != 0)
      for (int k = 0; k < WR; k++) chk($sformatf("lane%0d", k), int'($signed(out_data[k])), done[ptr*WR+k]);
  end

  function automatic int lanes(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic step(input bit v, input int d, input bit req, input bit prst, input bit rel);
    wr_valid = v; wr_data = NB'(d); req_chunk_in = req; req_chunk_ptr_rst = prst; rd_release = rel;
    @(posedge clk_in); #1;
    wr_valid = 0; wr_data = '0; req_chunk_in = 0; req_chunk_ptr_rst = 0; rd_release = 0;
  endtask

  task automatic do_reset();
    rst_in = 1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 0;
  endtask

  task automatic write_run(input int first, input int n, input bit req);
    for (int i = 0; i < n; i++) step(1, first + i, req, 0, 0);
  endtask

  initial begin
    // 1: reset / idle, then asynchronous reset clears outputs without an edge
    do_reset();
    step(0, 0, 0, 0, 0);
    chk("t1 ready", int'(out_data_ready), 0);
    chk("t1 lanes", int'(out_data), 0);
    chk("t1 ovf", int'(wr_overflow), 0);
    // 2: fill, chunk walk and wrap
    write_run(1, 8, 0);
    chk("t2 ready", int'(out_data_ready), 1);
    chk("t2 c0", int'(out_data), lanes(1, 2, 3, 4));
    step(0, 0, 1, 0, 0);
    chk("t2 c1", int'(out_data), lanes(5, 6, 7, 8));
    step(0, 0, 1, 0, 0);
    chk("t2 wrap", int'(out_data), lanes(1, 2, 3, 4));
    // 3: rewind and rewind-over-advance priority
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t3 rewind", int'(out_data), lanes(1, 2, 3, 4));
    step(0, 0, 1, 1, 0);
    chk("t3 both", int'(out_data), lanes(1, 2, 3, 4));
    // async reset between edges
    #2 rst_in = 1;
    #1;
    chk("t1 async ready", int'(out_data_ready), 0);
    chk("t1 async lanes", int'(out_data), 0);
    do_reset();
    // 4: ping-pong with release
    write_run(1, 8, 0);
    write_run(11, 8, 1);
    chk("t4 ready2", int'(out_data_ready), 1);
    step(0, 0, 0, 0, 1);
    chk("t4 swap", int'(out_data), lanes(11, 12, 13, 14));
    chk("t4 ready", int'(out_data_ready), 1);
    step(0, 0, 0, 0, 1);
    chk("t4 empty", int'(out_data_ready), 0);
    step(0, 0, 0, 0, 1);
    chk("t4 idle rel", int'(out_data_ready), 0);
    // 5: overflow drops the third vector
    do_reset();
    write_run(1, 24, 0);
    chk("t5 ovf", int'(wr_overflow), int'(OVF_EN));
    chk("t5 a", int'(out_data), lanes(1, 2, 3, 4));
    step(0, 0, 0, 0, 1);
    chk("t5 b", int'(out_data), lanes(9, 10, 11, 12));
    step(0, 0, 1, 0, 0);
    chk("t5 b1", int'(out_data), lanes(13, 14, 15, 16));
    step(0, 0, 0, 0, 1);
    chk("t5 empty", int'(out_data_ready), 0);
    // 6: reset mid-fill discards the partial vector
    do_reset();
    write_run(1, 5, 0);
    #2 rst_in = 1;
    #2 rst_in = 0;
    step(0, 0, 0, 0, 0);
    chk("t6 ready", int'(out_data_ready), 0);
    write_run(21, 7, 0);
    chk("t6 partial", int'(out_data_ready), 0);
    step(1, 28, 0, 0, 0);
    chk("t6 ready1", int'(out_data_ready), 1);
    chk("t6 c0", int'(out_data), lanes(21, 22, 23, 24));
    step(0, 0, 1, 0, 0);
    chk("t6 c1", int'(out_data), lanes(25, 26, 27, 28));
    repeat (3) @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_chunk_buffer.md
# vec_chunk_buffer

Ping-pong vector buffer that feeds chunked matrix-vector layers. It accepts a producer's output vector one element at a time and stores it in one of two banks. Once the vector is complete, it serves it to the consuming layer `WorkingRegs` elements per chunk, and it supports pointer advance and rewind requests. It sits between two layers: its write side takes the upstream layer's `req_chunk_out`/`write_out_data` stream, and its read side answers the downstream layer's `req_chunk_in`/`req_chunk_ptr_rst` requests.

## Interface
- `VecLength`, default 16: elements per vector. Must be a multiple of `WorkingRegs`; any other value is an elaboration error.
- `WorkingRegs`, default 4: elements per chunk.
- `NBits`, default 8: signed element width.
- Reset is asynchronous and active-high, on `rst_in`. There is a single clock, `clk_in`.
- `clk_in` in, 1: clock.
- `rst_in` in, 1: asynchronous active-high reset.
- `wr_valid` in, 1: element write strobe. Wired to the upstream `req_chunk_out`.
- `wr_data` in, `NBits` signed: element value. Wired to the upstream `write_out_data`.
- `req_chunk_in` in, 1: advance the read chunk pointer.
- `req_chunk_ptr_rst` in, 1: rewind the read chunk pointer to chunk 0.
- `rd_release` in, 1: the consumer is finished with the current vector. Wired to the downstream `out_vector_valid`.
- `out_data` out, `[WorkingRegs-1:0][NBits-1:0]` signed: the current chunk. Lane k holds vector element `ptr*WorkingRegs+k`.
- `out_data_ready` out, 1: at least one complete vector is held.
- `wr_overflow` out, 1: sticky overflow flag (see Configuration).

## Operation
- Storage: two banks, each holding `VecLength` elements.
- Registered state:
  - `wr_bank` and `wr_idx` (0..`VecLength`-1)
  - `rd_bank` and `rd_ptr` (0..`VecLength/WorkingRegs`-1)
  - `full_cnt` (0..2)
- Write path:
  - When `wr_valid` is high and `full_cnt` is below 2, `wr_data` is stored at `bank[wr_bank][wr_idx]` and `wr_idx` increments.
  - When `wr_idx` reaches `VecLength`-1, the write completes the vector: `wr_idx` goes to 0, `wr_bank` toggles, and `full_cnt` increments.
  - When `wr_valid` is high and `full_cnt` is 2, the write is dropped and no state changes.
- Read path: `out_data` is a combinational read of `bank[rd_bank]` chunk `rd_ptr`.
- Pointer update priority, highest first:
  - `req_chunk_ptr_rst` sets `rd_ptr` to 0.
  - Otherwise `req_chunk_in` increments `rd_ptr`, wrapping from the last chunk to 0.
- Release:
  - When `rd_release` is high and `full_cnt` is above 0: `rd_bank` toggles, `rd_ptr` goes to 0, and `full_cnt` decrements.
  - When `full_cnt` is 0, `rd_release` is ignored.
  - Release takes priority over pointer requests in the same cycle.
- Simultaneous vector completion and release: `full_cnt` is unchanged, and both bank pointers toggle.
- `out_data_ready` equals (`full_cnt` != 0), decoded from registered state.
- A partially filled vector is never visible to the read side.

## Timing
- Reset, asynchronous:
  - All pointers, `full_cnt` and `wr_overflow` clear to 0, and all bank contents clear to 0.
  - As a result, `out_data` reads 0 and `out_data_ready` reads 0 immediately on assertion, without waiting for a clock edge.
- Reset in the middle of a fill discards the partial vector.
- Write-to-ready latency: with `full_cnt` at 0, the final element is written at edge t and `out_data_ready` is high in the cycle after edge t.
- Chunk request latency: with `req_chunk_in` sampled at edge t, the new chunk is on `out_data` after edge t. The buffer behaves as a single-cycle FIFO, which matches a consumer that ingests a chunk every cycle.
- When `out_data_ready` rises, chunk 0 is already presented on `out_data`.
- Release latency: with release at edge t, the next vector's chunk 0 is on `out_data` after edge t when `full_cnt` was 2. In that case `out_data_ready` stays high through the swap.
- Writes can proceed at one element per cycle, continuously, while the other bank is being read.

## Configuration
- The feature is controlled by the macro `VEC_CHUNK_BUFFER_OVERFLOW_FLAG_EN`.
- With the macro defined:
  - `wr_overflow` is set at the edge where `wr_valid` is high and `full_cnt` is 2.
  - It stays set until reset.
  - A simulation-only assertion fires when an overflow occurs.
- Without the macro:
  - `wr_overflow` is tied to 0 and the assertion is absent.
  - Dropped-write behaviour is identical to the macro-defined case.

## Structure
- Shared package `vec_buf_pkg` contains:
  - the `bank_sel_t` typedef (1 bit);
  - a function computing chunk count and pointer width from `VecLength` and `WorkingRegs`.
- Sub-module `vec_bank` is one storage bank:
  - inputs: element write enable, element index and data;
  - output: combinational chunk read by chunk index;
  - asynchronous clear on reset.
- The top level instantiates two `vec_bank` instances and holds the pointer and count logic.

## Test plan
All scenarios use `VecLength`=8, `WorkingRegs`=4, `NBits`=8.
1. Reset, then idle: `out_data_ready`=0, all `out_data` lanes 0, `wr_overflow`=0. Assert `rst_in` between clock edges: outputs clear with no clock edge.
2. Write elements 1..8 on consecutive cycles: `out_data_ready`=1 one cycle after the 8th write, lanes read {1,2,3,4}. Pulse `req_chunk_in` and lanes read {5,6,7,8}; pulse again and they wrap to {1,2,3,4}.
3. Advance to chunk 1, then pulse `req_chunk_ptr_rst` alone: lanes read {1,2,3,4}. Pulse `req_chunk_in` and `req_chunk_ptr_rst` together: the pointer stays at chunk 0.
4. Write vector A (1..8), then vector B (11..18) while requesting chunks of A. Pulse `rd_release`: lanes read {11,12,13,14} and `out_data_ready` stays 1. Release again: `out_data_ready`=0.
5. Write 24 elements with no release: the third vector is dropped and `wr_overflow`=1, or 0 without the macro. After one release, lanes read vector B's chunk 0.
6. Write 5 elements, then pulse the asynchronous reset: `out_data_ready` stays 0. A subsequent write of 8 elements presents them starting from lane 0 of chunk 0.
